// File: rtl/micro_sequencer.sv
// Clocked microprogram sequencer: holds the micro-PC, picks the next control-store
// address from INST/SEQ/COND/DIRECT/CALL/RET sources and keeps a return-address stack.
`timescale 1ns/1ps
module micro_sequencer #(
  parameter int                ADDR_W      = 6,
  parameter int                NUM_FLAGS   = 4,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               stall,
  input  logic [2:0]                         next_sel,
  input  logic [ADDR_W-1:0]                  inst_branch,
  input  logic [ADDR_W-1:0]                  direct_branch,
  input  logic [$clog2(NUM_FLAGS)-1:0]       cond_sel,
  input  logic                               cond_inv,
  input  logic [NUM_FLAGS-1:0]               cond_flags,
  input  logic                               err_clr,
  output logic [ADDR_W-1:0]                  upc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
  output logic                               stack_overflow,
  output logic                               stack_underflow
);

  localparam int SEL_W = $clog2(NUM_FLAGS);
  localparam int CNT_W = $clog2(STACK_DEPTH+1);

  localparam logic [2:0] SEL_INST   = 3'd0;
  localparam logic [2:0] SEL_SEQ    = 3'd1;
  localparam logic [2:0] SEL_COND   = 3'd2;
  localparam logic [2:0] SEL_DIRECT = 3'd3;
  localparam logic [2:0] SEL_CALL   = 3'd4;
  localparam logic [2:0] SEL_RET    = 3'd5;

  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              und_q, und_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] target;
  logic              flag_sel;
  logic              cond_true;
  logic              stack_full;
  logic              stack_empty;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              und_set;
  logic              push_en;

  assign seq         = upc_q + ADDR_W'(1);
  assign stack_full  = (count_q == CNT_W'(STACK_DEPTH));
  assign stack_empty = (count_q == '0);

  // Out-of-range flag indices fall through the loop and read as 0.
  always_comb begin
    flag_sel = 1'b0;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (cond_sel == SEL_W'(i)) flag_sel = cond_flags[i];
    end
    cond_true = flag_sel ^ cond_inv;
  end

  // Top of stack is entry [count-1]; an empty stack never selects this value.
  always_comb begin
    stack_top = RESET_ADDR;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (count_q == CNT_W'(i + 1)) stack_top = stack_q[i];
    end
  end

  always_comb begin
    target  = seq;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    und_set = 1'b0;
    case (next_sel)
      SEL_INST:   target = inst_branch;
      SEL_SEQ:    target = seq;
      SEL_COND:   target = cond_true ? direct_branch : seq;
      SEL_DIRECT: target = direct_branch;
      SEL_CALL: begin
        target = direct_branch;
        if (stack_full) ovf_set = 1'b1;
        else            push    = 1'b1;
      end
      SEL_RET: begin
        if (stack_empty) begin
          target  = RESET_ADDR;
          und_set = 1'b1;
        end else begin
          target = stack_top;
          pop    = 1'b1;
        end
      end
      default:    target = seq;
    endcase
  end

  // Stall freezes PC and stack but the sticky clear still acts; a new error wins over clear.
  always_comb begin
    upc_d   = upc_q;
    count_d = count_q;
    if (!stall) begin
      upc_d = target;
      if (push)     count_d = count_q + CNT_W'(1);
      else if (pop) count_d = count_q - CNT_W'(1);
    end
    ovf_d = (ovf_q & ~err_clr) | (ovf_set & ~stall);
    und_d = (und_q & ~err_clr) | (und_set & ~stall);
  end

  assign push_en = push & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc_q   <= RESET_ADDR;
      count_q <= '0;
      ovf_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      upc_q   <= upc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      und_q   <= und_d;
    end
  end

  // Stack storage is deliberately not reset; only the count is.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push_en && (count_q == CNT_W'(i))) stack_q[i] <= seq;
    end
  end

  assign upc             = upc_q;
  assign stack_count     = count_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = und_q;

endmodule
